// File: rtl/neuron_mac.sv
// Weighted sum of N_INPUTS (x,w) pairs plus bias, rounded and saturated to signed Q2.5 for the sigmoid stage.
// Latency: start accepted in cycle 0, back-to-back beats in cycles 1..N_INPUTS, out_valid pulses in cycle N_INPUTS+2.
// Backpressure: in_ready is high only while accumulating; stalls (in_valid low) simply hold the partial sum.
module neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bias,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x,
    input  logic [7:0] w,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] out
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] SAT_LO = -(ACC_W+1)'(127);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        DONE
    } state_t;

    state_t state, state_nx;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        count;
    logic [7:0]              out_r;

    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   rnd;
    logic [7:0]              sat;

    assign prod     = $signed(x) * $signed(w);
    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    assign bias_ext = {{(ACC_W-13){bias[7]}}, bias, 5'b0};

    // One guard bit so the +16 rounding offset can never wrap the accumulator.
    assign rnd_sum = {acc[ACC_W-1], acc} + (ACC_W+1)'(16);
    assign rnd     = rnd_sum >>> 5;

    always_comb begin
        sat = rnd[7:0];
        if (rnd > SAT_HI) begin
            sat = 8'h7F;
        end else if (rnd < SAT_LO) begin
            sat = 8'h81;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && count == LAST) begin
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            count <= '0;
            out_r <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= bias_ext;
                        count <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc   <= acc + prod_ext;
                        count <= count + CNT_W'(1);
                    end
                end
                ROUND: begin
                    out_r <= sat;
                end
                default: begin
                end
            endcase
        end
    end

    assign out = out_r;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: stimulus pushes expected results and signal checks into queues,
// a negedge monitor pops and compares them against the DUT.
module tb_neuron_mac;

    localparam int K_OUT  = 0;
    localparam int K_RDY  = 1;
    localparam int K_BUSY = 2;
    localparam int K_OV   = 3;
    localparam int K_HS   = 4;
    localparam int K_SBE  = 5;

    typedef struct {
        int    kind;
        int    exp;
        string name;
    } req_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] bias;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] w;
    logic       busy;
    logic       out_valid;
    logic [7:0] out;

    logic [7:0] exp_q[$];
    req_t       req_q[$];

    int n_chk;
    int n_fail;
    int hs_cnt;
    int exp_hs;

    neuron_mac #(
        .N_INPUTS(4),
        .ACC_W   (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .w        (w),
        .busy     (busy),
        .out_valid(out_valid),
        .out      (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: sole owner of the counters.
    initial begin
        logic [7:0] e;
        req_t       r;
        int         act;
        n_chk  = 0;
        n_fail = 0;
        hs_cnt = 0;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                hs_cnt++;
            end
            if (out_valid) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got out=%h, required no pulse", out);
                end else begin
                    e = exp_q.pop_front();
                    if (out !== e) begin
                        n_fail++;
                        $display("FAIL result: got out=%h, required %h", out, e);
                    end
                end
            end
            while (req_q.size() > 0) begin
                r = req_q.pop_front();
                case (r.kind)
                    K_OUT:   act = int'(out);
                    K_RDY:   act = int'(in_ready);
                    K_BUSY:  act = int'(busy);
                    K_OV:    act = int'(out_valid);
                    K_HS:    act = hs_cnt;
                    default: act = exp_q.size();
                endcase
                n_chk++;
                if (act != r.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0d, required %0d", r.name, act, r.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int k, input int e, input string n);
        req_t r;
        r.kind = k;
        r.exp  = e;
        r.name = n;
        req_q.push_back(r);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) begin
            chk(K_BUSY, 0, "timeout_idle");
        end
    endtask

    // One evaluation with identical beats; stalls>0 also exercises ignored start/in_valid cases.
    task automatic run(input logic [7:0] b, input logic [7:0] xv, input logic [7:0] wv,
                       input int stalls, input logic [7:0] e, input string n);
        exp_q.push_back(e);
        start = 1'b1;
        bias  = b;
        if (stalls > 0) begin
            in_valid = 1'b1;
            x        = xv;
            w        = wv;
            chk(K_RDY, 0, {n, "_rdy_idle"});
        end
        tick();
        start    = 1'b0;
        bias     = 8'h55;
        in_valid = 1'b0;
        chk(K_BUSY, 1, {n, "_busy_accum"});
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x        = xv;
            w        = wv;
            tick();
            in_valid = 1'b0;
            x        = 8'h7F;
            w        = 8'h7F;
            if (i < 3) begin
                for (int s = 0; s < stalls; s++) begin
                    if (s == 1) begin
                        start = 1'b1;
                        chk(K_RDY, 1, {n, "_rdy_stall"});
                    end
                    tick();
                    start = 1'b0;
                end
            end
        end
        exp_hs += 4;
        if (stalls > 0) begin
            in_valid = 1'b1;
        end
        chk(K_RDY, 0, {n, "_rdy_round"});
        chk(K_BUSY, 1, {n, "_busy_round"});
        chk(K_OV, 0, {n, "_ov_round"});
        tick();
        in_valid = 1'b0;
        start    = 1'b1;
        chk(K_OV, 1, {n, "_ov_done"});
        chk(K_BUSY, 1, {n, "_busy_done"});
        tick();
        start = 1'b0;
        chk(K_OV, 0, {n, "_ov_after"});
        chk(K_BUSY, 0, {n, "_busy_after"});
        chk(K_OUT, int'(e), {n, "_out_hold"});
        wait_idle();
        chk(K_HS, exp_hs, {n, "_handshakes"});
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        bias     = 8'h00;
        in_valid = 1'b0;
        x        = 8'h00;
        w        = 8'h00;
        exp_hs   = 0;
        tick();
        tick();
        chk(K_OUT, 0, "reset_out");
        chk(K_BUSY, 0, "reset_busy");
        chk(K_RDY, 0, "reset_rdy");
        chk(K_OV, 0, "reset_ov");
        reset = 1'b0;
        tick();

        run(8'h00, 8'h20, 8'h20, 0, 8'h7F, "sat_pos");
        run(8'h08, 8'h10, 8'h20, 0, 8'h48, "bias_quarter");
        run(8'h00, 8'hE0, 8'h20, 0, 8'h81, "sat_neg");
        run(8'h00, 8'h01, 8'h01, 0, 8'h00, "round_zero");
        run(8'h00, 8'h04, 8'h04, 0, 8'h02, "round_half");
        run(8'h08, 8'h10, 8'h20, 3, 8'h48, "stalls");

        // Reset mid-evaluation after two beats.
        start = 1'b1;
        bias  = 8'h08;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x        = 8'h10;
            w        = 8'h20;
            tick();
        end
        in_valid = 1'b0;
        exp_hs += 2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk(K_BUSY, 0, "midreset_busy");
        chk(K_RDY, 0, "midreset_rdy");
        chk(K_OUT, 0, "midreset_out");
        chk(K_OV, 0, "midreset_ov");
        repeat (8) tick();
        chk(K_HS, exp_hs, "midreset_handshakes");
        run(8'h08, 8'h10, 8'h20, 0, 8'h48, "after_reset");

        repeat (4) tick();
        chk(K_SBE, 0, "scoreboard_empty");
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
